mc_control_unit: RTL

Main sequencing FSM for the multicycle CPU. It decodes the opcode and funct fields of the instruction register and drives every datapath mux select, the write enables and the memory request. Each instruction takes 3–5 states. It sits between the instruction register and the datapath's 2:1 and 4:1 selectors, the register file, the ALU and the unified memory port.

---
 rtl/cpu_ctrl_pkg.sv | 33 +++
 rtl/alu_decoder.sv | 22 ++
 rtl/mc_control_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared encodings for the multicycle CPU control unit
package cpu_ctrl_pkg;
  typedef enum logic [3:0] {
    S_IF, S_ID, S_MADR, S_MRD, S_MWB, S_MWR, S_EXR, S_WBR, S_EXI, S_WBI, S_BR, S_JMP
  } state_t;
  typedef enum logic [2:0] {AC_NONE, AC_ADD, AC_SUB, AC_FUNCT, AC_IMM} alu_class_t;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] F_ADD    = 6'h20;
  localparam logic [5:0] F_SUB    = 6'h22;
  localparam logic [5:0] F_AND    = 6'h24;
  localparam logic [5:0] F_OR     = 6'h25;
  localparam logic [5:0] F_SLT    = 6'h2A;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [1:0] SB_B     = 2'b00;
  localparam logic [1:0] SB_FOUR  = 2'b01;
  localparam logic [1:0] SB_IMM   = 2'b10;
  localparam logic [1:0] SB_SHL2  = 2'b11;
  localparam logic [1:0] PS_ALU   = 2'b00;
  localparam logic [1:0] PS_OUT   = 2'b01;
  localparam logic [1:0] PS_JUMP  = 2'b10;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps (state class, op, funct) to alu_ctrl / ext_zero and flags unsupported funct
module alu_decoder
  import cpu_ctrl_pkg::*;
(
  input  alu_class_t  cls,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  output logic [3:0]  alu_ctrl,
  output logic        ext_zero,
  output logic        bad_funct
);
  logic [3:0] fn_ctrl, imm_ctrl;
  always_comb begin
    fn_ctrl   = funct == F_ADD ? ALU_ADD : funct == F_SUB ? ALU_SUB :
                funct == F_AND ? ALU_AND : funct == F_OR  ? ALU_OR  : ALU_SLT;
    bad_funct = !(funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT});
    imm_ctrl  = op == OP_ANDI ? ALU_AND : op == OP_ORI ? ALU_OR : ALU_ADD;
    alu_ctrl  = cls == AC_ADD ? ALU_ADD : cls == AC_SUB ? ALU_SUB :
                cls == AC_FUNCT ? fn_ctrl : cls == AC_IMM ? imm_ctrl : 4'b0000;
    ext_zero  = cls == AC_IMM && (op == OP_ANDI || op == OP_ORI);
  end
endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle CPU sequencing FSM driving datapath selects, enables and memory requests
module mc_control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic [3:0] alu_ctrl,
  output logic [1:0] pc_source,
  output logic       pc_write,
  output logic       instr_done,
  output logic       illegal
);
  state_t     state, next;
  alu_class_t cls;
  logic       bad_funct;
  alu_decoder u_dec (.cls(cls), .op(op), .funct(funct), .alu_ctrl(alu_ctrl), .ext_zero(ext_zero), .bad_funct(bad_funct));
  always_ff @(posedge clk)
    state <= rst ? S_IF : next;
  // outputs stay at their zero defaults whenever rst is high, whatever the state
  always_comb begin
    next       = state;
    cls        = AC_NONE;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SB_B;
    pc_source  = PS_ALU;
    pc_write   = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    if (!rst)
      case (state)
        S_IF: begin
          mem_req   = 1'b1;
          alu_src_b = SB_FOUR;
          cls       = AC_ADD;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          next      = mem_ready ? S_ID : S_IF;
        end
        S_ID: begin
          alu_src_b = SB_SHL2;
          cls       = AC_ADD;
          case (op)
            OP_LW, OP_SW:              next = S_MADR;
            OP_RTYPE:                  next = bad_funct ? S_IF : S_EXR;
            OP_ADDI, OP_ANDI, OP_ORI:  next = S_EXI;
            OP_BEQ, OP_BNE:            next = S_BR;
            OP_J:                      next = S_JMP;
            default:                   next = S_IF;
          endcase
          illegal = next == S_IF;
        end
        S_MADR: begin
          alu_src_a = 1'b1;
          alu_src_b = SB_IMM;
          cls       = AC_ADD;
          next      = op == OP_LW ? S_MRD : S_MWR;
        end
        S_MRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          next    = mem_ready ? S_MWB : S_MRD;
        end
        S_MWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
          next       = S_IF;
        end
        S_MWR: begin
          mem_req    = 1'b1;
          mem_write  = 1'b1;
          iord       = 1'b1;
          instr_done = mem_ready;
          next       = mem_ready ? S_IF : S_MWR;
        end
        S_EXR: begin
          alu_src_a = 1'b1;
          cls       = AC_FUNCT;
          next      = S_WBR;
        end
        S_WBR: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
          next       = S_IF;
        end
        S_EXI: begin
          alu_src_a = 1'b1;
          alu_src_b = SB_IMM;
          cls       = AC_IMM;
          next      = S_WBI;
        end
        S_WBI: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          next       = S_IF;
        end
        S_BR: begin
          alu_src_a  = 1'b1;
          cls        = AC_SUB;
          pc_source  = PS_OUT;
          pc_write   = op == OP_BEQ ? zero : ~zero;
          instr_done = 1'b1;
          next       = S_IF;
        end
        S_JMP: begin
          pc_source  = PS_JUMP;
          pc_write   = 1'b1;
          instr_done = 1'b1;
          next       = S_IF;
        end
        default: next = S_IF;
      endcase
  end
endmodule
